// File: rtl/hart_mem_responder.sv
// Single-port SRAM responder shared by a hart's fetch and data ports.
// Each access takes exactly two cycles: issue in IDLE, deliver in RESP_I/RESP_D.
// Data requests win arbitration, except right after a data response, where the
// always-pending fetch is given one turn so instruction fetch cannot starve.
module hart_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           imem_addr,
  output logic                  imem_stall,
  output logic [31:0]           imem_data,
  input  logic                  dmem_req,
  input  logic [31:0]           dmem_addr,
  input  logic [3:0]            dmem_wmask,
  input  logic [31:0]           dmem_wdata,
  output logic                  dmem_stall,
  output logic [31:0]           dmem_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [3:0]            sram_wen,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RESP_I = 2'd1;
  localparam logic [1:0] RESP_D = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        fetch_prio;
  logic        d_read;
  logic        grant_d;
  logic [31:0] imem_hold;
  logic [31:0] dmem_hold;

  // Byte-offset and out-of-range address bits are deliberately dropped (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr[31:ADDR_WIDTH+2], imem_addr[1:0],
                              dmem_addr[31:ADDR_WIDTH+2], dmem_addr[1:0]};

  // State, anti-starvation flag, access kind and response hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_prio <= 1'b0;
      d_read     <= 1'b0;
      imem_hold  <= 32'h0;
      dmem_hold  <= 32'h0;
    end else begin
      state      <= state_nxt;
      fetch_prio <= (state == RESP_D);
      if (state == IDLE && grant_d) begin
        d_read <= (dmem_wmask == 4'b0000);
      end
      if (state == RESP_I) begin
        imem_hold <= sram_rdata;
      end
      if (state == RESP_D && d_read) begin
        dmem_hold <= sram_rdata;
      end
    end
  end

  // Arbitration, next state and SRAM request drive.
  always_comb begin
    state_nxt  = state;
    grant_d    = dmem_req && !fetch_prio;
    sram_addr  = imem_addr[ADDR_WIDTH+1:2];
    sram_wen   = 4'b0000;
    sram_wdata = dmem_wdata;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = RESP_D;
          sram_addr = dmem_addr[ADDR_WIDTH+1:2];
          if (!rst) begin
            sram_wen = dmem_wmask;
          end
        end else begin
          state_nxt = RESP_I;
        end
      end
      RESP_I: begin
        state_nxt = IDLE;
      end
      RESP_D: begin
        state_nxt = IDLE;
        sram_addr = dmem_addr[ADDR_WIDTH+1:2];
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stall flags and data returned to the hart: live SRAM data in the response
  // cycle, held copy otherwise.
  always_comb begin
    imem_stall = (state != RESP_I);
    dmem_stall = dmem_req && (state != RESP_D);
    imem_data  = (state == RESP_I) ? sram_rdata : imem_hold;
    dmem_rdata = (state == RESP_D && d_read) ? sram_rdata : dmem_hold;
  end

endmodule
